// File: rtl/road_pkg.sv
// Road selection codes and FSM state encoding shared by road_select
// and the downstream light controller.
package road_pkg;

  // One-hot road codes as seen on Road_SW; all-zero means no road.
  localparam logic [2:0] ROAD_NONE = 3'b000;
  localparam logic [2:0] ROAD_A    = 3'b100;
  localparam logic [2:0] ROAD_B    = 3'b010;
  localparam logic [2:0] ROAD_C    = 3'b001;

  typedef enum logic [1:0] {
    ST_NONE   = 2'd0,
    ST_ROAD_A = 2'd1,
    ST_ROAD_B = 2'd2,
    ST_ROAD_C = 2'd3
  } road_state_e;

  // Output code driven for each FSM state.
  function automatic logic [2:0] road_code(input road_state_e s);
    case (s)
      ST_ROAD_A: road_code = ROAD_A;
      ST_ROAD_B: road_code = ROAD_B;
      ST_ROAD_C: road_code = ROAD_C;
      default:   road_code = ROAD_NONE;
    endcase
  endfunction

  // Auto-mode rotation A -> B -> C -> A; NONE enters the cycle at A.
  function automatic road_state_e next_road(input road_state_e s);
    case (s)
      ST_ROAD_A: next_road = ST_ROAD_B;
      ST_ROAD_B: next_road = ST_ROAD_C;
      default:   next_road = ST_ROAD_A;
    endcase
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a consecutive-mismatch debouncer
// for one raw switch input.
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic db_o
);

  localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);

  logic        sync1_q;
  logic        sync2_q;
  logic        db_q;
  logic [23:0] cnt_q;

  // Bring the asynchronous switch into the clock domain.
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else if (sync2_q == db_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      db_q  <= ~db_q;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 24'd1;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/road_select.sv
// Road selector: debounced manual road switches or timed auto rotation,
// producing a registered one-hot road code with valid and change strobes.
module road_select
  import road_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned AUTO_CYCLES     = 1050000000
) (
  input  logic       CLK_50MHz,
  input  logic       Res_n,
  input  logic [2:0] SW_raw,
  input  logic       Auto_en,
  output logic [2:0] Road_SW,
  output logic       Sel_valid,
  output logic       Change_pulse
);

  localparam logic [30:0] AUTO_LAST = 31'(AUTO_CYCLES - 1);

  logic [3:0]  raw_all;
  logic [3:0]  db_all;
  logic [2:0]  sw_db;
  logic        auto_db;

  road_state_e state_q, state_d;
  logic [30:0] dwell_q, dwell_d;
  logic [2:0]  road_sw_q;
  logic        sel_valid_q;
  logic        change_q;

  assign raw_all = {Auto_en, SW_raw};

  for (genvar i = 0; i < 4; i++) begin : g_db
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (CLK_50MHz),
      .rst_n(Res_n),
      .raw_i(raw_all[i]),
      .db_o (db_all[i])
    );
  end

  assign auto_db = db_all[3];
  assign sw_db   = db_all[2:0];

  // Next road: timed rotation in auto mode, exact one-hot switch in manual mode.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    dwell_d = '0;
    if (auto_db) begin
      if (state_q == ST_NONE) begin
        state_d = ST_ROAD_A;
      end else if (dwell_q == AUTO_LAST) begin
        state_d = next_road(state_q);
      end else if (dwell_q != '1) begin
        dwell_d = dwell_q + 31'd1;
      end else begin
        dwell_d = dwell_q;
      end
    end else begin
      case (sw_db)
        ROAD_A:  state_d = ST_ROAD_A;
        ROAD_B:  state_d = ST_ROAD_B;
        ROAD_C:  state_d = ST_ROAD_C;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM state, dwell timer and the registered outputs that follow the state.
  always_ff @(posedge CLK_50MHz or negedge Res_n) begin
    if (!Res_n) begin
      state_q     <= ST_NONE;
      dwell_q     <= '0;
      road_sw_q   <= ROAD_NONE;
      sel_valid_q <= 1'b0;
      change_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      road_sw_q   <= road_code(state_d);
      sel_valid_q <= (state_d != ST_NONE);
      change_q    <= (state_d != state_q);
    end
  end

  assign Road_SW      = road_sw_q;
  assign Sel_valid    = sel_valid_q;
  assign Change_pulse = change_q;

endmodule

// File: tb/tb_road_select.sv
// Randomised bench for road_select with an edge-level behavioural model
// (short debounce and dwell times) plus hand-computed latency checks.
module tb_road_select;

  localparam int DB   = 4;
  localparam int AUTO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] sw_raw = 3'b000;
  logic       auto_en = 1'b0;
  logic [2:0] road_sw;
  logic       sel_valid;
  logic       change_pulse;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  bit cmp_en = 1'b0;

  road_select #(
    .DEBOUNCE_CYCLES(DB),
    .AUTO_CYCLES    (AUTO)
  ) dut (
    .CLK_50MHz   (clk),
    .Res_n       (rst_n),
    .SW_raw      (sw_raw),
    .Auto_en     (auto_en),
    .Road_SW     (road_sw),
    .Sel_valid   (sel_valid),
    .Change_pulse(change_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each input bit is seen two edges late; an accepted level changes on the
  // edge that completes DB consecutive disagreeing samples. The road is a
  // one-hot vector; auto mode rotates it right after AUTO edges in a road.
  bit [3:0]   m_s1 = '0, m_s2 = '0, m_acc = '0;
  int         m_streak [4] = '{0, 0, 0, 0};
  int         m_dwell = 0;
  logic [2:0] m_road = 3'b000;
  logic       m_valid = 1'b0, m_pulse = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s1 = '0; m_s2 = '0; m_acc = '0;
        for (int b = 0; b < 4; b++) m_streak[b] = 0;
        m_dwell = 0; m_road = 3'b000; m_valid = 1'b0; m_pulse = 1'b0;
      end else begin
        logic [2:0] nr;
        nr = m_road;
        if (m_acc[3]) begin
          if (m_road == 3'b000) nr = 3'b100;
          else if (m_dwell == AUTO - 1) nr = {m_road[0], m_road[2:1]};
        end else if ($countones(m_acc[2:0]) == 1) begin
          nr = m_acc[2:0];
        end
        m_dwell = (!m_acc[3] || nr != m_road) ? 0 : m_dwell + 1;
        m_pulse = (nr != m_road);
        m_road  = nr;
        m_valid = (nr != 3'b000);
        for (int b = 0; b < 4; b++) begin
          if (m_s2[b] != m_acc[b]) begin
            m_streak[b]++;
            if (m_streak[b] == DB) begin
              m_acc[b] = ~m_acc[b];
              m_streak[b] = 0;
            end
          end else begin
            m_streak[b] = 0;
          end
        end
        m_s2 = m_s1;
        m_s1 = {auto_en, sw_raw};
      end
    end
  end

  // Compare DUT against the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (change_pulse === 1'b1) pulse_cnt++;
      if (cmp_en) begin
        check("model_road",  32'(road_sw),      32'(m_road));
        check("model_valid", 32'(sel_valid),    32'(m_valid));
        check("model_pulse", 32'(change_pulse), 32'(m_pulse));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold reset for two cycles, release on a falling edge.
  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
  endtask

  // Count rising edges (first edge = 1) until Road_SW equals target; -1 on timeout.
  // When rnd is set, SW is randomised before every edge.
  task automatic wait_road(input logic [2:0] target, input bit rnd, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      if (rnd) begin
        @(negedge clk);
        sw_raw = 3'($urandom);
      end
      @(posedge clk);
      #1;
      if (road_sw == target) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  int p0;

  initial begin
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    sw_raw = 3'b100;
    cycles(3);
    check("reset_road",  32'(road_sw),      32'h0);
    check("reset_valid", 32'(sel_valid),    32'h0);
    check("reset_pulse", 32'(change_pulse), 32'h0);

    // Release with A held: road appears at edge index 6 (first edge = index 0).
    rst_n = 1'b1;
    wait_road(3'b100, 1'b0, n);
    check("release_latency_A", 32'(n), 32'd7);
    check("release_pulse_on",  32'(change_pulse), 32'd1);
    check("release_valid",     32'(sel_valid),    32'd1);
    @(posedge clk); #1;
    check("release_pulse_off", 32'(change_pulse), 32'd0);

    // Three-cycle glitch to B is rejected.
    @(negedge clk);
    p0 = pulse_cnt;
    sw_raw = 3'b010;
    cycles(3);
    sw_raw = 3'b100;
    cycles(15);
    check("glitch_road",   32'(road_sw),         32'(3'b100));
    check("glitch_pulses", 32'(pulse_cnt - p0),  32'd0);

    // Move to B, then multi-bit and all-zero switches hold B.
    p0 = pulse_cnt;
    sw_raw = 3'b010;
    cycles(10);
    check("manual_B", 32'(road_sw), 32'(3'b010));
    sw_raw = 3'b110;
    cycles(10);
    check("hold_multi", 32'(road_sw), 32'(3'b010));
    sw_raw = 3'b000;
    cycles(10);
    check("hold_zero",     32'(road_sw),        32'(3'b010));
    check("manual_pulses", 32'(pulse_cnt - p0), 32'd1);

    // Auto mode from NONE: A, then 8 edges per road, SW ignored.
    sw_raw = 3'b000;
    auto_en = 1'b1;
    pulse_reset();
    wait_road(3'b100, 1'b0, n);
    check("auto_entry_A", 32'(n), 32'd7);
    p0 = pulse_cnt;
    wait_road(3'b010, 1'b1, n);
    check("auto_A_to_B", 32'(n), 32'd8);
    wait_road(3'b001, 1'b1, n);
    check("auto_B_to_C", 32'(n), 32'd8);
    wait_road(3'b100, 1'b1, n);
    check("auto_C_to_A", 32'(n), 32'd8);
    wait_road(3'b010, 1'b1, n);
    check("auto_A_to_B2", 32'(n), 32'd8);
    wait_road(3'b001, 1'b1, n);
    check("auto_B_to_C2", 32'(n), 32'd8);
    check("auto_pulses", 32'(pulse_cnt - p0), 32'd5);

    // Leave auto in C with A requested: C held one edge past acceptance, then A.
    @(negedge clk);
    sw_raw = 3'b100;
    auto_en = 1'b0;
    wait_road(3'b100, 1'b0, n);
    check("auto_exit_latency", 32'(n), 32'd7);

    // Auto entry from a road keeps it and restarts dwell; reset mid-dwell in B.
    @(negedge clk);
    auto_en = 1'b1;
    wait_road(3'b010, 1'b0, n);
    check("auto_keep_A_then_B", 32'(n), 32'd14);
    cycles(3);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_road",  32'(road_sw),      32'h0);
    check("async_reset_valid", 32'(sel_valid),    32'h0);
    check("async_reset_pulse", 32'(change_pulse), 32'h0);
    sw_raw = 3'b010;
    auto_en = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    p0 = pulse_cnt;
    wait_road(3'b010, 1'b0, n);
    check("recover_latency_B", 32'(n), 32'd7);
    cycles(10);
    check("recover_pulses", 32'(pulse_cnt - p0), 32'd1);

    // Random segments with occasional asynchronous resets.
    for (int seg = 0; seg < 300; seg++) begin
      @(negedge clk);
      sw_raw  = 3'($urandom);
      auto_en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
      cycles($urandom_range(1, 12));
    end

    cycles(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
